// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: folds E0/F0 prefixes into key events and resets the receiver only when a prefix sequence stalls.
// Optional auto-repeat suppression is built when PS2_TYPEMATIC_FILTER_EN is defined.
module ps2_key_ctrl #(
    parameter int TIMEOUT_CYC = 12500000,
    parameter int RST_LEN     = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_done_tick_i,
    input  logic [7:0] rx_dout_i,
    output logic       rx_en_o,
    output logic       rx_reset_o,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_break_o,
    output logic       key_valid_o,
    input  logic       key_ack_i,
    output logic       overflow_o
);

    typedef enum logic [2:0] {
        IDLE,
        GOT_E0,
        GOT_F0,
        GOT_E0F0,
        RXRST
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] wd_q, wd_d;
    logic [3:0]  rcnt_q, rcnt_d;

    logic        kv_q, kv_d;
    logic [7:0]  code_q, code_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic        ovf_q, ovf_d;

    logic        ev_fire;
    logic        ev_ext;
    logic        ev_brk;
    logic        ev_emit;
    logic        suppress;
    logic        is_e0, is_f0, is_err;

    assign is_e0  = (rx_dout_i == 8'hE0);
    assign is_f0  = (rx_dout_i == 8'hF0);
    assign is_err = (rx_dout_i == 8'h00) || (rx_dout_i == 8'hFF);

    // Sequencer and watchdog
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        rcnt_d  = rcnt_q;
        ev_fire = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_done_tick_i) begin
                    if (is_e0)       state_d = GOT_E0;
                    else if (is_f0)  state_d = GOT_F0;
                    else if (!is_err) ev_fire = 1'b1;
                end
            end
            GOT_E0: begin
                if (rx_done_tick_i) begin
                    if (is_f0)       state_d = GOT_E0F0;
                    else if (is_e0)  state_d = GOT_E0;
                    else begin
                        state_d = IDLE;
                        ev_fire = !is_err;
                        ev_ext  = 1'b1;
                    end
                end
            end
            GOT_F0: begin
                if (rx_done_tick_i) begin
                    if (is_f0)       state_d = GOT_F0;
                    else if (is_e0)  state_d = GOT_E0F0;
                    else begin
                        state_d = IDLE;
                        ev_fire = !is_err;
                        ev_brk  = 1'b1;
                    end
                end
            end
            GOT_E0F0: begin
                if (rx_done_tick_i) begin
                    if (!(is_e0 || is_f0)) begin
                        state_d = IDLE;
                        ev_fire = !is_err;
                        ev_ext  = 1'b1;
                        ev_brk  = 1'b1;
                    end
                end
            end
            RXRST: begin
                if (rcnt_q == 4'(RST_LEN - 1)) begin
                    state_d = IDLE;
                    rcnt_d  = 4'd0;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick in the same cycle as expiry wins: the byte above is processed.
        if (state_q == GOT_E0 || state_q == GOT_F0 || state_q == GOT_E0F0) begin
            if (rx_done_tick_i) begin
                wd_d = 24'd0;
            end else if (wd_q == 24'(TIMEOUT_CYC - 1)) begin
                state_d = RXRST;
                wd_d    = 24'd0;
                rcnt_d  = 4'd0;
            end else begin
                wd_d = wd_q + 24'd1;
            end
        end else begin
            wd_d = 24'd0;
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_q, held_d;
    logic [8:0] last_q, last_d;
    logic       same_key;

    assign same_key = (last_q == {ev_ext, rx_dout_i});
    assign suppress = ev_fire && !ev_brk && held_q && same_key;

    always_comb begin
        held_d = held_q;
        last_d = last_q;
        if (state_q != RXRST && state_d == RXRST) begin
            held_d = 1'b0;
        end else if (ev_fire && !suppress) begin
            if (!ev_brk) begin
                held_d = 1'b1;
                last_d = {ev_ext, rx_dout_i};
            end else if (held_q && same_key) begin
                held_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            held_q <= 1'b0;
            last_q <= 9'd0;
        end else begin
            held_q <= held_d;
            last_q <= last_d;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign ev_emit = ev_fire && !suppress;

    // Event holding register with valid/ack handshake and sticky drop flag
    always_comb begin
        kv_d   = kv_q;
        code_d = code_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        ovf_d  = ovf_q;
        if (ev_emit) begin
            if (!kv_q || key_ack_i) begin
                kv_d   = 1'b1;
                code_d = rx_dout_i;
                ext_d  = ev_ext;
                brk_d  = ev_brk;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (key_ack_i && kv_q) begin
            kv_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            wd_q    <= 24'd0;
            rcnt_q  <= 4'd0;
            kv_q    <= 1'b0;
            code_q  <= 8'h00;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            rcnt_q  <= rcnt_d;
            kv_q    <= kv_d;
            code_q  <= code_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            ovf_q   <= ovf_d;
        end
    end

    assign rx_reset_o  = reset_i || (state_q == RXRST);
    assign rx_en_o     = (state_q != RXRST);
    assign key_valid_o = kv_q;
    assign key_code_o  = code_q;
    assign key_ext_o   = ext_q;
    assign key_break_o = brk_q;
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: prefix decoding, handshake, overflow, watchdog abort and reset.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       key_ack = 1'b0;
    logic       rx_en, rx_reset, key_ext, key_break, key_valid, overflow;
    logic [7:0] key_code;

    int errors = 0;
    int checks = 0;
    int waited;
    int pulse_len;
    int events;

    ps2_key_ctrl #(.TIMEOUT_CYC(100), .RST_LEN(4)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .rx_done_tick_i (rx_done_tick),
        .rx_dout_i      (rx_dout),
        .rx_en_o        (rx_en),
        .rx_reset_o     (rx_reset),
        .key_code_o     (key_code),
        .key_ext_o      (key_ext),
        .key_break_o    (key_break),
        .key_valid_o    (key_valid),
        .key_ack_i      (key_ack),
        .overflow_o     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL sim_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte is presented for one cycle; returns on the negedge after the capturing posedge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        rx_dout = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        $display("tx byte %02h -> valid=%0b code=%02h ext=%0b brk=%0b ovf=%0b",
                 b, key_valid, key_code, key_ext, key_break, overflow);
    endtask

    task automatic ack();
        @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_event(input string tag, input logic [7:0] code, input logic ext, input logic brk);
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        check({tag, "_code"},  32'(key_code),  32'(code));
        check({tag, "_ext"},   32'(key_ext),   32'(ext));
        check({tag, "_brk"},   32'(key_break), 32'(brk));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rx_reset_hi", 32'(rx_reset), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_code",  32'(key_code),  32'h00);
        check("rst_ext",   32'(key_ext),   32'd0);
        check("rst_brk",   32'(key_break), 32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);
        check("rst_rx_en", 32'(rx_en),     32'd1);
        check("rst_rx_reset_lo", 32'(rx_reset), 32'd0);

        // Plain press then break
        send(8'h1C);
        check_event("press_1c", 8'h1C, 1'b0, 1'b0);
        ack();
        check("ack_clears_valid", 32'(key_valid), 32'd0);
        check("code_held_after_ack", 32'(key_code), 32'h1C);
        send(8'hF0);
        check("f0_no_event", 32'(key_valid), 32'd0);
        send(8'h1C);
        check_event("break_1c", 8'h1C, 1'b0, 1'b1);
        ack();

        // Extended press and break
        send(8'hE0);
        send(8'h75);
        check_event("press_e075", 8'h75, 1'b1, 1'b0);
        ack();
        send(8'hE0);
        send(8'hF0);
        check("e0f0_no_event", 32'(key_valid), 32'd0);
        send(8'h75);
        check_event("break_e075", 8'h75, 1'b1, 1'b1);
        ack();

        // Error codes produce nothing
        send(8'h00);
        send(8'hFF);
        check("err_codes_no_event", 32'(key_valid), 32'd0);

        // Watchdog abort after a stalled E0
        send(8'hE0);
        waited = 0;
        while (rx_reset !== 1'b1 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("wd_fire_cycle", 32'(waited), 32'd100);
        pulse_len = 0;
        while (rx_reset === 1'b1 && rx_en === 1'b0 && pulse_len < 50) begin
            @(negedge clk);
            pulse_len++;
        end
        check("wd_pulse_len", 32'(pulse_len), 32'd4);
        check("wd_rx_en_back", 32'(rx_en), 32'd1);
        send(8'h1C);
        check_event("after_wd_1c", 8'h1C, 1'b0, 1'b0);
        ack();

        // Overflow: second event dropped while first is pending
        do_reset();
        send(8'h1C);
        send(8'h32);
        check_event("ovf_held", 8'h1C, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        ack();
        check("ovf_ack_valid", 32'(key_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Auto-repeat sequence
        do_reset();
        check("ovf_cleared_by_reset", 32'(overflow), 32'd0);
        events = 0;
        send(8'h1C); if (key_valid === 1'b1) begin events++; ack(); end
        send(8'h1C); if (key_valid === 1'b1) begin events++; ack(); end
        send(8'h1C); if (key_valid === 1'b1) begin events++; ack(); end
        send(8'hF0); if (key_valid === 1'b1) begin events++; ack(); end
        send(8'h1C); if (key_valid === 1'b1) begin events++; ack(); end
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typematic_events", 32'(events), 32'd2);
`else
        check("typematic_events", 32'(events), 32'd4);
`endif

        // Reset while in GOT_E0F0 with an event pending
        send(8'h1C);
        send(8'hE0);
        send(8'hF0);
        check("pre_reset_valid", 32'(key_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_valid",    32'(key_valid), 32'd0);
        check("mid_rst_code",     32'(key_code),  32'h00);
        check("mid_rst_ext",      32'(key_ext),   32'd0);
        check("mid_rst_brk",      32'(key_break), 32'd0);
        check("mid_rst_ovf",      32'(overflow),  32'd0);
        check("mid_rst_rx_en",    32'(rx_en),     32'd1);
        check("mid_rst_rx_reset", 32'(rx_reset),  32'd1);
        reset = 1'b0;
        send(8'h75);
        check_event("post_rst_75", 8'h75, 1'b0, 1'b0);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
